key_sampler: RTL and testbench
==============================

// Module: key_sampler
// PURPOSE
//  Input-conditioning stage directly upstream of the pattern-detector FSM.
//  Synchronises and debounces the raw active-low push-button and generates
//  the slow sample tick internally. Emits exactly one sampled bit per tick
//  period as a one-cycle sample_valid strobe. The detector consumes this
//  strobe in place of a divided clock, so the design stays on one clock domain.
// PARAMETERS
//  TICK_CYCLES      50_000_000  clk cycles per sample period (1 Hz at 50 MHz); >= 2
//  DEBOUNCE_CYCLES  500_000     consecutive cycles a change must persist (10 ms); >= 1
//  STICKY           1           1: bit=1 if a press was seen anywhere in the period; 0: level at tick
// PORTS
//  clk           in   1  system clock (CLOCK_50 at top level)
//  rst_n         in   1  asynchronous active-low reset
//  key_n         in   1  raw push-button, 0 = pressed, asynchronous to clk
//  pressed       out  1  debounced level, 1 = pressed
//  sample_bit    out  1  sampled bit for the current period; valid when sample_valid=1
//  sample_valid  out  1  one-cycle strobe, once per TICK_CYCLES
//  tick_led      out  1  ~50% duty square wave at the tick rate, for LED display
// BEHAVIOUR
//  Reset (async, rst_n=0): sync flops=1 (released); pressed=0; sample_bit=0;
//   sample_valid=0; press_seen=0; debounce cnt=0; tick cnt=0; tick_led=1.
//  Synchroniser: 2-flop chain on key_n; only the second-stage output is used.
//  Debounce: cnt increments each cycle sync!=~pressed. Any cycle where they
//   agree clears cnt. When cnt==DEBOUNCE_CYCLES-1 and they still differ,
//   pressed toggles and cnt clears. Latency: pressed changes on the
//   (DEBOUNCE_CYCLES+2)th rising edge counting the first edge that samples
//   the new key_n level. Release uses the same rule.
//  Counter widths: $clog2 of the respective parameter (min 1 bit).
//   Counters never overflow.
//  Tick: tcnt counts 0..TICK_CYCLES-1, then wraps to 0. tick = (tcnt==TICK_CYCLES-1).
//  tick_led: registered. It is 1 while tcnt < TICK_CYCLES/2, else 0.
//  press_seen: set on any cycle pressed=1, cleared on the tick cycle.
//   Press on the tick cycle itself: counts toward the closing period only.
//  On the tick edge: sample_valid<=1 for exactly one cycle.
//   sample_bit <= STICKY ? (press_seen|pressed) : pressed.
//   sample_bit holds its value until the next tick.
//  sample_valid: never high on two consecutive cycles. First strobe occurs
//   TICK_CYCLES edges after reset deassertion.
//  Reset mid-period: all state returns to reset values immediately.
//   No partial-period strobe is emitted after release.
//  No handshake/backpressure: consumer must accept each strobe.
//   The strobe is the FSM clock-enable.
// TESTING  (TICK_CYCLES=16, DEBOUNCE_CYCLES=4, STICKY=1 unless stated)
//  1 Reset: rst_n=0 mid-run -> all outputs 0 and tick_led=1 same cycle.
//    After release, first sample_valid on edge 16, sample_bit=0.
//  2 Debounce latency: key_n 1->0 held -> pressed=1 on 6th edge sampling 0.
//    Release -> pressed=0 on 6th edge sampling 1.
//  3 Glitch reject: key_n low for 3 samples, or bouncing 1-cycle pulses
//    for 20 cycles -> pressed stays 0, no sample_bit=1.
//  4 Sticky capture: debounced press of 8 cycles inside one period
//    -> next strobe sample_bit=1; following period idle -> sample_bit=0.
//    Same stimulus with STICKY=0, released before tick -> sample_bit=0.
//  5 Boundary: pressed rises exactly on tick cycle -> counted in closing
//    period (bit=1), and press_seen cleared for the next period.
//  6 Stream: hold key for 3 full periods -> three strobes with bit=1.
//    Strobes are 16 cycles apart, each 1 cycle wide, and the downstream
//    detector output asserts after the third strobe.

Source files
------------

// File: rtl/key_sampler.sv
// Key conditioner: 2-flop sync, debounce, internal sample tick, one sampled bit per tick period.
// Latency: pressed follows key_n after DEBOUNCE_CYCLES+2 edges; sample_valid fires on each tick edge.
// No backpressure: the consumer must take every sample_valid strobe as it occurs.
module key_sampler #(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit STICKY          = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic sample_bit,
    output logic sample_valid,
    output logic tick_led
);

    localparam int TW = (TICK_CYCLES > 1)     ? $clog2(TICK_CYCLES)     : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICK_CYCLES / 2);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          press_seen;
    logic          differ;
    logic          tick;

    // Flops reset to 1 so the chain starts in the released state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // sync2 is active-low, so equality with pressed means the two disagree.
    always_comb begin
        differ   = (sync2 == pressed);
        tick     = (tcnt == TICK_LAST);
        tcnt_nxt = tick ? '0 : tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (!differ) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt  <= '0;
            pressed <= ~pressed;
        end else begin
            db_cnt  <= db_cnt + 1'b1;
        end
    end

    // tick_led is driven from the next count so it stays aligned with tcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            tick_led <= 1'b1;
        end else begin
            tcnt     <= tcnt_nxt;
            tick_led <= (tcnt_nxt < TICK_HALF);
        end
    end

    // A press during the tick cycle lands in the closing period via the direct pressed term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_seen   <= 1'b0;
            sample_bit   <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick;
            if (tick) begin
                press_seen <= 1'b0;
                sample_bit <= STICKY ? (press_seen | pressed) : pressed;
            end else if (pressed) begin
                press_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_sampler.sv
// Directed bench for key_sampler (TICK=16, DEBOUNCE=4) with sticky and non-sticky instances.
// Expected sample bits are queued per period as stimulus is applied and checked on each strobe.
module tb_key_sampler;

    logic clk = 1'b0;
    logic rst_n;
    logic key_n;

    logic pr_s, sb_s, sv_s, led_s;
    logic pr_n, sb_n, sv_n, led_n;

    always #5 clk = ~clk;

    key_sampler #(.TICK_CYCLES(16), .DEBOUNCE_CYCLES(4), .STICKY(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .pressed(pr_s), .sample_bit(sb_s), .sample_valid(sv_s), .tick_led(led_s)
    );

    key_sampler #(.TICK_CYCLES(16), .DEBOUNCE_CYCLES(4), .STICKY(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .pressed(pr_n), .sample_bit(sb_n), .sample_valid(sv_n), .tick_led(led_n)
    );

    int   tests = 0;
    int   fails = 0;
    int   ecount;
    logic exp_s[$];
    logic exp_n[$];
    int   strobes_s = 0;
    int   strobes_n = 0;
    logic prev_sv_s = 1'b0;
    logic prev_sv_n = 1'b0;
    int   run = 0;
    logic det = 1'b0;

    // Edge index since the last reset release; edge 1 is the first posedge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at_edge(input int e);
        while (ecount < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pressed(input logic val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (pr_s === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic push_exp(input logic s, input logic n);
        exp_s.push_back(s);
        exp_n.push_back(n);
    endtask

    // Strobe monitor and a small downstream detector: asserts after three consecutive 1 bits.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sv_s === 1'b1) begin
                strobes_s <= strobes_s + 1;
                chk("strobe_phase_s", ecount % 16, 0);
                chk("strobe_width_s", prev_sv_s, 0);
                chk("strobe_expected_s", exp_s.size() > 0, 1);
                if (exp_s.size() > 0) chk("sample_bit_s", sb_s, exp_s.pop_front());
                run <= (sb_s === 1'b1) ? run + 1 : 0;
                det <= (sb_s === 1'b1) && (run + 1 >= 3);
            end
            if (sv_n === 1'b1) begin
                strobes_n <= strobes_n + 1;
                chk("strobe_phase_n", ecount % 16, 0);
                chk("strobe_width_n", prev_sv_n, 0);
                chk("strobe_expected_n", exp_n.size() > 0, 1);
                if (exp_n.size() > 0) chk("sample_bit_n", sb_n, exp_n.pop_front());
            end
        end
        prev_sv_s <= sv_s;
        prev_sv_n <= sv_n;
    end

    initial begin
        int   n;
        logic glitch_seen;

        key_n = 1'b1;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("reset_pressed", pr_s, 0);
        chk("reset_sample_bit", sb_s, 0);
        chk("reset_sample_valid", sv_s, 0);
        chk("reset_tick_led", led_s, 1);
        chk("reset_tick_led_n", led_n, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Period 1 idle.
        push_exp(1'b0, 1'b0);
        at_edge(3);
        chk("tick_led_first_half", led_s, 1);
        at_edge(10);
        chk("tick_led_second_half", led_s, 0);

        // Period 2: debounce latency on press and release.
        at_edge(18);
        push_exp(1'b1, 1'b0);
        key_n = 1'b0;
        wait_pressed(1'b1, 20, n);
        chk("press_latency", n, 6);
        chk("press_level_n", pr_n, 1);
        key_n = 1'b1;
        wait_pressed(1'b0, 20, n);
        chk("release_latency", n, 6);

        // Periods 3-4: a 3-sample low pulse, then 1-cycle bounce.
        at_edge(34);
        push_exp(1'b0, 1'b0);
        push_exp(1'b0, 1'b0);
        key_n = 1'b0;
        at_edge(37);
        key_n = 1'b1;
        glitch_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            key_n = ~key_n;
            if (pr_s !== 1'b0) glitch_seen = 1'b1;
        end
        at_edge(62);
        chk("glitch_seen", glitch_seen, 0);
        chk("glitch_pressed", pr_s, 0);

        // Period 5: 8-cycle debounced press released before the tick; period 6 idle.
        at_edge(64);
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
        key_n = 1'b0;
        wait_pressed(1'b1, 20, n);
        chk("sticky_press_edge", ecount, 70);
        at_edge(72);
        key_n = 1'b1;
        at_edge(79);
        chk("released_before_tick", pr_s, 0);

        // Period 7: pressed rises on the tick cycle; periods 8-9 follow.
        at_edge(105);
        push_exp(1'b1, 1'b1);
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
        key_n = 1'b0;
        wait_pressed(1'b1, 20, n);
        chk("boundary_latency", n, 6);
        chk("boundary_edge", ecount, 111);
        key_n = 1'b1;

        // Periods 10-12: key held for three full periods.
        at_edge(138);
        push_exp(1'b1, 1'b1);
        push_exp(1'b1, 1'b1);
        push_exp(1'b1, 1'b1);
        key_n = 1'b0;
        at_edge(177);
        chk("detector_before_third", det, 0);
        at_edge(193);
        chk("detector_after_third", det, 1);
        chk("stream_sample_bit", sb_s, 1);

        // Mid-period reset with key held and sample_bit high.
        at_edge(202);
        chk("pre_reset_tick_led", led_s, 0);
        chk("pre_reset_pressed", pr_s, 1);
        rst_n = 1'b0;
        key_n = 1'b1;
        #1;
        chk("midreset_pressed", pr_s, 0);
        chk("midreset_sample_bit", sb_s, 0);
        chk("midreset_sample_valid", sv_s, 0);
        chk("midreset_tick_led", led_s, 1);
        chk("midreset_pressed_n", pr_n, 0);
        chk("midreset_tick_led_n", led_n, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(1'b0, 1'b0);
        at_edge(12);
        chk("no_partial_strobe_s", strobes_s, 12);
        chk("no_partial_strobe_n", strobes_n, 12);
        at_edge(20);
        chk("total_strobes_s", strobes_s, 13);
        chk("total_strobes_n", strobes_n, 13);
        chk("queue_drained_s", exp_s.size(), 0);
        chk("queue_drained_n", exp_n.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
